// File: rtl/pc_jr_fetch.sv
// rtl/pc_jr_fetch.sv - MIPS-subset fetch/next-PC unit with JR support; optional macro JR_ALIGN_CHECK_EN
module pc_jr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        resolve_valid,
    input  logic        jr_control,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] instr_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_halted;

    logic [31:0] w_pc4;
    logic [31:0] w_branch_off;
    logic [31:0] w_jr_target;
    logic        w_jr_fault;
    logic [31:0] w_next_pc;

    // JR target and misalignment policy depend on the build option
`ifdef JR_ALIGN_CHECK_EN
    assign w_jr_target = rs_data;
    assign w_jr_fault  = jr_control && (rs_data[1:0] != 2'b00);
`else
    assign w_jr_target = rs_data & 32'hFFFF_FFFC;
    assign w_jr_fault  = 1'b0;
`endif

    // Next-PC selection: JR beats jump beats taken branch beats sequential
    always_comb begin
        w_pc4        = r_pc + 32'd4;
        w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_next_pc    = w_pc4;
        if (jr_control) begin
            w_next_pc = w_jr_target;
        end else if (jump) begin
            w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
        end else if (branch && zero) begin
            w_next_pc = w_pc4 + w_branch_off;
        end
    end

    // Fetch/issue FSM with registered handshake outputs; reset has top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_count       <= 32'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr       <= imem_data;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (resolve_valid && w_jr_fault) begin
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                        r_state       <= S_HALT;
                    end else if (resolve_valid) begin
                        r_pc          <= w_next_pc;
                        r_count       <= r_count + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign instr_count = r_count;
    assign halted      = r_halted;

endmodule
